button_debounce_multi: RTL
==========================

Name: button_debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer for the stopwatch/clock designs.
- Each channel: synchronises a raw pushbutton, samples it on a shared slow tick, and requires N consecutive agreeing samples before the debounced level changes.
- Per channel it emits a debounced level, one-clk press and release pulses, and optional auto-repeat pulses while held (fast time-setting).
- Sits between the board button pins and the mode/adjust control FSMs.

Parameters:
- N_BTN, 4: number of independent button channels.
- SAMPLE_DIV, 500000: clk cycles per sample tick; must be >= 2.
- STABLE_CNT, 3: consecutive disagreeing samples needed to change the debounced level; must be >= 1.
- REPEAT_DELAY, 100: ticks the button is held after the press before the first repeat pulse.
- REPEAT_RATE, 25: ticks between later repeat pulses; 0 disables repeat on all channels.

Ports:
- clk, input, 1: system clock; all state on its rising edge.
- rst, input, 1: reset, asynchronous and active-high; clears all state.
- btn_in, input, N_BTN: raw asynchronous button inputs, 1 = pressed.
- btn_level, output, N_BTN: debounced level per channel.
- btn_press, output, N_BTN: one-clk pulse when the debounced level goes 0->1.
- btn_release, output, N_BTN: one-clk pulse when the debounced level goes 1->0.
- btn_repeat, output, N_BTN: one-clk auto-repeat pulse while held.
- sample_tick, output, 1: one-clk strobe marking each sample instant; for debug and tests.

Behaviour:
- Reset:
  - All outputs are 0.
  - Divider is 0, synchroniser flops are 0, stability and hold counters are 0.
  - Reset asserted mid-operation aborts any in-progress debounce or repeat immediately with no pulses.
  - A button held across reset release is seen as a new press after the normal debounce latency.
- Divider:
  - Counts 0..SAMPLE_DIV-1 and wraps to 0.
  - The internal tick is high for exactly the one clk where the count is SAMPLE_DIV-1, i.e. one tick every SAMPLE_DIV clks.
  - sample_tick is that tick.
  - Width is clog2(SAMPLE_DIV).
- Synchroniser: two flops per channel; sync = second flop. sync is never used unsynchronised.
- Per channel, evaluated only on clk edges where tick = 1:
  - If sync == btn_level: stability count is cleared to 0.
  - Else if count == STABLE_CNT-1: btn_level is toggled and count is cleared.
  - Else: count is incremented.
  - A glitch of fewer than STABLE_CNT consecutive samples never changes btn_level.
- Pulses:
  - btn_press and btn_release are registered.
  - Each is high for exactly the one clk in which btn_level first shows its new value, i.e. the cycle after the tick edge that toggles it.
  - Both are 0 on all other cycles. Press and release on the same channel never overlap.
- Auto-repeat, per channel, REPEAT_RATE != 0:
  - Hold counter is 0 while btn_level = 0, and is cleared on the press edge.
  - On each tick while btn_level = 1 the hold counter increments.
  - btn_repeat pulses (registered, one clk, aligned to the clk after that tick) when the counter reaches REPEAT_DELAY.
  - After that it pulses every REPEAT_RATE ticks: the counter reloads to REPEAT_DELAY-REPEAT_RATE.
  - The counter saturates safely and never wraps to a spurious pulse.
  - Release clears it the same edge btn_level falls; no repeat on or after the release edge.
- Latency: a clean input edge reaches btn_level after 2 clk of synchronisation plus STABLE_CNT ticks, i.e. between (STABLE_CNT-1)*SAMPLE_DIV+3 and STABLE_CNT*SAMPLE_DIV+2 clk.
- Channels are fully independent. Simultaneous events on different channels all pulse in the same cycle.

Test Plan:
- Parameters for all scenarios: SAMPLE_DIV=4, STABLE_CNT=3, REPEAT_DELAY=5, REPEAT_RATE=2, N_BTN=4.
- Reset and divider: hold rst 10 clk, then release -> all outputs 0 during reset; sample_tick high on clk 4, 8, 12 after release, exactly 1 clk wide.
- Clean press/release on ch0: btn_in[0]=1 for 60 clk, then 0 -> btn_level[0] rises 3 ticks after sync; btn_press[0] is a single 1-clk pulse coincident with the rise; btn_release[0] is a single pulse 3 ticks after the input falls; other channels stay 0.
- Bounce rejection on ch1: toggle btn_in[1] at irregular 1–9 clk intervals for 40 clk, then settle at 1 -> no pulses during bouncing; exactly one btn_press[1] after the final stable 3 ticks.
- Auto-repeat on ch2: hold for 30 ticks -> btn_press[2] once; btn_repeat[2] on ticks 5, 7, 9, ... after the press; no repeat after release.
- Simultaneous events: press ch0 and ch3 on the same clk -> btn_press[0] and btn_press[3] pulse in the same cycle.
- Mid-debounce reset: assert rst after 2 agreeing ticks -> outputs 0 at once; after release with the button still held, btn_press fires only after a full 3 fresh ticks.

Source files
------------

// File: rtl/button_debounce_multi.sv
// Multi-channel pushbutton debouncer: two-flop synchroniser, shared sample tick,
// N-sample agreement filter, press/release pulses and optional auto-repeat while held.
module button_debounce_multi #(
    parameter int N_BTN        = 4,
    parameter int SAMPLE_DIV   = 500000,
    parameter int STABLE_CNT   = 3,
    parameter int REPEAT_DELAY = 100,
    parameter int REPEAT_RATE  = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             sample_tick
);

    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W  = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam int HOLD_W = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(REPEAT_DELAY);
    // A rate not shorter than the delay reloads to zero, so the repeat period becomes the delay.
    localparam logic [HOLD_W-1:0] HOLD_RELOAD =
        (REPEAT_RATE >= REPEAT_DELAY) ? '0 : HOLD_W'(REPEAT_DELAY - REPEAT_RATE);
    localparam bit REPEAT_EN = (REPEAT_RATE != 0) && (REPEAT_DELAY != 0);

    logic [DIV_W-1:0] div_reg;
    logic             tick;
    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;

    assign tick        = (div_reg == DIV_LAST);
    assign sample_tick = tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg   <= '0;
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            div_reg   <= tick ? '0 : div_reg + 1'b1;
            sync1_reg <= btn_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_chan
            logic              level_reg;
            logic              press_reg;
            logic              release_reg;
            logic              repeat_reg;
            logic [CNT_W-1:0]  cnt_reg;
            logic [HOLD_W-1:0] hold_reg;
            logic              differ;
            logic              flip;
            logic [HOLD_W-1:0] hold_inc;

            always_comb begin
                differ   = sync2_reg[gi] ^ level_reg;
                flip     = tick && differ && (cnt_reg == CNT_LAST);
                hold_inc = hold_reg + 1'b1;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    repeat_reg  <= 1'b0;
                    cnt_reg     <= '0;
                    hold_reg    <= '0;
                end else begin
                    press_reg   <= flip & ~level_reg;
                    release_reg <= flip & level_reg;
                    repeat_reg  <= 1'b0;
                    if (tick) begin
                        if (!differ) begin
                            cnt_reg <= '0;
                        end else if (flip) begin
                            cnt_reg   <= '0;
                            level_reg <= ~level_reg;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                        // Hold counter only advances while held; press and release edges both clear it.
                        if (!level_reg || flip) begin
                            hold_reg <= '0;
                        end else if (REPEAT_EN && (hold_reg < HOLD_FIRE)) begin
                            if (hold_inc == HOLD_FIRE) begin
                                repeat_reg <= 1'b1;
                                hold_reg   <= HOLD_RELOAD;
                            end else begin
                                hold_reg <= hold_inc;
                            end
                        end
                    end
                end
            end

            assign btn_level[gi]   = level_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;
            assign btn_repeat[gi]  = repeat_reg;
        end
    endgenerate

endmodule
